// File: rtl/uart_host_ctrl.sv
// Host-side TX/RX byte FIFOs in front of uart_top's parallel interface; the TX FSM feeds one byte per frame.
// Optional statistics counters (tx_count, rx_count, drop_count) are built when UART_HOST_STATS_EN is defined.
module uart_host_ctrl #(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 104,
   parameter int TIMEOUT_BITS = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [7:0]             wr_data,
   output logic                   tx_full,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic                   tx_busy,
   output logic                   tx_timeout,
   input  logic                   rd_en,
   output logic [7:0]             rd_data,
   output logic                   rx_empty,
   output logic [$clog2(DEPTH):0] rx_level,
   output logic                   rx_overrun,
   input  logic                   flag_clr,
   output logic [7:0]             uart_dintx,
   output logic                   uart_send,
   input  logic                   uart_donetx,
   input  logic [7:0]             uart_doutrx,
   input  logic                   uart_donerx
`ifdef UART_HOST_STATS_EN
   ,
   output logic [15:0]            tx_count,
   output logic [15:0]            rx_count,
   output logic [7:0]             drop_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
   localparam logic [CW-1:0] SEND_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;
   state_t state, state_nx;

   logic [CW-1:0] cnt;
   logic          done_seen, tx_done_evt, tx_to_evt;
   logic          donetx_p0, donerx_p0, tx_rise_p1, rx_rise_p1;
   logic [7:0]    rx_byte_p1;
   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
   logic          tx_push, tx_pop, rx_full, rx_push, rx_pop, rx_drop;

   // Stage p0 -> p1: registered rising-edge detect of the uart_top strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         donetx_p0  <= 1'b0;
         donerx_p0  <= 1'b0;
         tx_rise_p1 <= 1'b0;
         rx_rise_p1 <= 1'b0;
      end else begin
         donetx_p0  <= uart_donetx;
         donerx_p0  <= uart_donerx;
         tx_rise_p1 <= uart_donetx & ~donetx_p0;
         rx_rise_p1 <= uart_donerx & ~donerx_p0;
      end
   end

   always_ff @(posedge clk) rx_byte_p1 <= uart_doutrx;

   assign tx_full  = (tx_level == FULL_LVL);
   assign tx_push  = wr_en && !tx_full;
   assign tx_pop   = (state == LOAD);
   assign rx_full  = (rx_level == FULL_LVL);
   assign rx_empty = (rx_level == '0);
   assign rx_pop   = rd_en && !rx_empty;
   assign rx_push  = rx_rise_p1 && (!rx_full || rx_pop);
   assign rx_drop  = rx_rise_p1 && rx_full && !rx_pop;
   assign rd_data  = rx_empty ? 8'h00 : rx_mem[rx_rptr];

   assign uart_send = (state == SEND);
   assign tx_busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr] <= wr_data;
      if (rx_push) rx_mem[rx_wptr] <= rx_byte_p1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wptr    <= '0;
         tx_rptr    <= '0;
         tx_level   <= '0;
         rx_wptr    <= '0;
         rx_rptr    <= '0;
         rx_level   <= '0;
         rx_overrun <= 1'b0;
         uart_dintx <= 8'h00;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop) begin
            tx_rptr    <= tx_rptr + 1'b1;
            uart_dintx <= tx_mem[tx_rptr];
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_level <= tx_level + 1'b1;
            2'b01:   tx_level <= tx_level - 1'b1;
            default: tx_level <= tx_level;
         endcase
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_level <= rx_level + 1'b1;
            2'b01:   rx_level <= rx_level - 1'b1;
            default: rx_level <= rx_level;
         endcase
         if (rx_drop)       rx_overrun <= 1'b1;
         else if (flag_clr) rx_overrun <= 1'b0;
      end
   end

   always_comb begin
      state_nx    = state;
      tx_done_evt = 1'b0;
      tx_to_evt   = 1'b0;
      case (state)
         IDLE: if (tx_level != '0) state_nx = LOAD;
         LOAD: state_nx = SEND;
         SEND: if (cnt == SEND_LAST) state_nx = WAIT;
         WAIT: begin
            // A completion seen while still sending is honoured as soon as WAIT starts
            if (done_seen || tx_rise_p1) begin
               state_nx    = GAP;
               tx_done_evt = 1'b1;
            end else if (cnt == WAIT_LAST) begin
               state_nx  = GAP;
               tx_to_evt = 1'b1;
            end
         end
         GAP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         done_seen  <= 1'b0;
         tx_timeout <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx != state)                  cnt <= '0;
         else if (state == SEND || state == WAIT) cnt <= cnt + 1'b1;
         if (state == LOAD)                      done_seen <= 1'b0;
         else if (state == SEND && tx_rise_p1)   done_seen <= 1'b1;
         if (tx_to_evt)     tx_timeout <= 1'b1;
         else if (flag_clr) tx_timeout <= 1'b0;
      end
   end

`ifdef UART_HOST_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_count   <= '0;
         rx_count   <= '0;
         drop_count <= '0;
      end else begin
         if (tx_done_evt) tx_count <= tx_count + 1'b1;
         if (rx_push)     rx_count <= rx_count + 1'b1;
         if (rx_drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
      end
   end
`else
   // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed self-checking bench for uart_host_ctrl (default parameters).
module tb_uart_host_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       tx_full, tx_busy, tx_timeout;
   logic [4:0] tx_level, rx_level;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rx_empty, rx_overrun;
   logic       flag_clr = 1'b0;
   logic [7:0] uart_dintx;
   logic       uart_send;
   logic       uart_donetx = 1'b0;
   logic [7:0] uart_doutrx = 8'h00;
   logic       uart_donerx = 1'b0;
`ifdef UART_HOST_STATS_EN
   logic [15:0] tx_count, rx_count;
   logic [7:0]  drop_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_host_ctrl #(.DEPTH(16), .CLKS_PER_BIT(104), .TIMEOUT_BITS(12)) dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_level(tx_level),
      .tx_busy(tx_busy), .tx_timeout(tx_timeout),
      .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_level(rx_level),
      .rx_overrun(rx_overrun), .flag_clr(flag_clr),
      .uart_dintx(uart_dintx), .uart_send(uart_send), .uart_donetx(uart_donetx),
      .uart_doutrx(uart_doutrx), .uart_donerx(uart_donerx)
`ifdef UART_HOST_STATS_EN
      , .tx_count(tx_count), .rx_count(rx_count), .drop_count(drop_count)
`endif
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rx_byte(input logic [7:0] b, input int hold);
      uart_doutrx = b;
      uart_donerx = 1'b1;
      tick(hold);
      uart_donerx = 1'b0;
      tick(1);
   endtask

   task automatic donetx_pulse();
      uart_donetx = 1'b1;
      tick(1);
      uart_donetx = 1'b0;
   endtask

   task automatic test_reset();
      tick(2);
      total++;
      if ({tx_full, tx_level, tx_busy, tx_timeout, rx_level, rx_overrun, uart_send} !== 15'd0) begin
         bad++;
         $display("FAIL reset_zero: got %b want 0", {tx_full, tx_level, tx_busy, tx_timeout, rx_level, rx_overrun, uart_send});
      end
      total++;
      if (rx_empty !== 1'b1) begin bad++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
      total++;
      if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      total++;
      if (uart_dintx !== 8'h00) begin bad++; $display("FAIL reset_dintx: got %h want 00", uart_dintx); end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_single();
      int first, highs;
      logic dintx_bad;
      first = -1; highs = 0; dintx_bad = 1'b0;
      wr_data = 8'hA5; wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
      total++;
      if (uart_send !== 1'b0) begin bad++; $display("FAIL single_send_early: got %b want 0", uart_send); end
      for (int n = 1; n < 400; n++) begin
         tick(1);
         if (uart_send === 1'b1) begin
            if (first < 0) first = n;
            highs++;
            if (uart_dintx !== 8'hA5) dintx_bad = 1'b1;
         end else if (first >= 0) break;
      end
      total++;
      if (first != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", first); end
      total++;
      if (highs != 104) begin bad++; $display("FAIL single_send_len: got %0d want 104", highs); end
      total++;
      if (dintx_bad !== 1'b0) begin bad++; $display("FAIL single_dintx_stable: got unstable want A5"); end
      tick(19);
      total++;
      if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_wait: got %b want 1", tx_busy); end
      donetx_pulse();
      tick(4);
      total++;
      if ({tx_busy, tx_timeout} !== 2'b00) begin bad++; $display("FAIL single_done: got %b want 00", {tx_busy, tx_timeout}); end
      total++;
      if (uart_dintx !== 8'hA5) begin bad++; $display("FAIL single_dintx_hold: got %h want A5", uart_dintx); end
   endtask

   task automatic test_early_done();
      int w;
      wr_data = 8'hC3; wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
      w = 0;
      while (uart_send !== 1'b1 && w < 10) begin tick(1); w++; end
      tick(10);
      donetx_pulse();
      w = 0;
      while (uart_send === 1'b1 && w < 200) begin tick(1); w++; end
      tick(2);
      total++;
      if ({tx_busy, tx_timeout} !== 2'b00) begin bad++; $display("FAIL early_done: got %b want 00", {tx_busy, tx_timeout}); end
   endtask

   task automatic test_timeout();
      int w, n;
      for (int i = 0; i < 17; i++) begin
         wr_data = i[7:0]; wr_en = 1'b1;
         tick(1);
      end
      wr_en = 1'b0;
      total++;
      if ({tx_full, tx_level} !== {1'b1, 5'd16}) begin bad++; $display("FAIL to_full: got %b/%0d want 1/16", tx_full, tx_level); end
      wr_data = 8'h11; wr_en = 1'b1;
      tick(1);
      wr_en = 1'b0;
      total++;
      if (tx_level !== 5'd16) begin bad++; $display("FAIL to_write_when_full: got %0d want 16", tx_level); end
      w = 0;
      while (uart_send === 1'b1 && w < 300) begin tick(1); w++; end
      n = 0;
      while (tx_timeout !== 1'b1 && n < 1400) begin tick(1); n++; end
      total++;
      if (n != 1248) begin bad++; $display("FAIL to_wait_cycles: got %0d want 1248", n); end
      total++;
      if (uart_dintx !== 8'h00) begin bad++; $display("FAIL to_dintx_first: got %h want 00", uart_dintx); end
      w = 0;
      while (uart_send !== 1'b1 && w < 10) begin tick(1); w++; end
      total++;
      if ({uart_dintx, tx_level} !== {8'h01, 5'd15}) begin bad++; $display("FAIL to_next_load: got %h/%0d want 01/15", uart_dintx, tx_level); end
      flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      total++;
      if (tx_timeout !== 1'b0) begin bad++; $display("FAIL to_flag_clr: got %b want 0", tx_timeout); end
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
   endtask

   task automatic test_rx_overrun();
      logic [7:0] e;
      rx_byte(8'h30, 5);
      for (int i = 1; i < 16; i++) rx_byte(8'h30 + i[7:0], 1);
      total++;
      if ({rx_level, rx_overrun, rx_empty} !== {5'd16, 1'b0, 1'b0}) begin bad++; $display("FAIL rx_fill: got %0d/%b/%b want 16/0/0", rx_level, rx_overrun, rx_empty); end
      rx_byte(8'h40, 1);
      total++;
      if ({rx_level, rx_overrun, rd_data} !== {5'd16, 1'b1, 8'h30}) begin bad++; $display("FAIL rx_overrun: got %0d/%b/%h want 16/1/30", rx_level, rx_overrun, rd_data); end
      for (int i = 0; i < 16; i++) begin
         e = 8'h30 + i[7:0];
         total++;
         if (rd_data !== e) begin bad++; $display("FAIL rx_pop_%0d: got %h want %h", i, rd_data, e); end
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
      end
      total++;
      if ({rx_level, rx_empty} !== {5'd0, 1'b1}) begin bad++; $display("FAIL rx_drained: got %0d/%b want 0/1", rx_level, rx_empty); end
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      total++;
      if ({rx_level, rx_empty, rd_data} !== {5'd0, 1'b1, 8'h00}) begin bad++; $display("FAIL rx_pop_empty: got %0d/%b/%h want 0/1/00", rx_level, rx_empty, rd_data); end
   endtask

   task automatic test_rx_simul();
      logic [7:0] e;
      for (int i = 0; i < 16; i++) rx_byte(8'h50 + i[7:0], 1);
      flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      total++;
      if (rx_overrun !== 1'b0) begin bad++; $display("FAIL simul_clr: got %b want 0", rx_overrun); end
      uart_doutrx = 8'h60; uart_donerx = 1'b1;
      tick(1);
      uart_donerx = 1'b0; rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      total++;
      if ({rx_level, rx_overrun, rd_data} !== {5'd16, 1'b0, 8'h51}) begin bad++; $display("FAIL simul_push_pop: got %0d/%b/%h want 16/0/51", rx_level, rx_overrun, rd_data); end
      for (int i = 0; i < 16; i++) begin
         e = (i == 15) ? 8'h60 : 8'h51 + i[7:0];
         total++;
         if (rd_data !== e) begin bad++; $display("FAIL simul_pop_%0d: got %h want %h", i, rd_data, e); end
         rd_en = 1'b1;
         tick(1);
         rd_en = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int w;
      for (int i = 0; i < 16; i++) rx_byte(8'h70 + i[7:0], 1);
      uart_doutrx = 8'h80; uart_donerx = 1'b1;
      tick(1);
      uart_donerx = 1'b0; flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      total++;
      if (rx_overrun !== 1'b1) begin bad++; $display("FAIL set_beats_clr: got %b want 1", rx_overrun); end
      for (int i = 0; i < 4; i++) begin
         wr_data = 8'hD0 + i[7:0]; wr_en = 1'b1;
         tick(1);
      end
      wr_en = 1'b0;
      w = 0;
      while (uart_send !== 1'b1 && w < 10) begin tick(1); w++; end
      tick(10);
      total++;
      if ({uart_send, tx_level} !== {1'b1, 5'd3}) begin bad++; $display("FAIL mid_queued: got %b/%0d want 1/3", uart_send, tx_level); end
      #3 rst = 1'b0;
      #1;
      total++;
      if ({uart_send, tx_busy} !== 2'b00) begin bad++; $display("FAIL mid_async_send: got %b want 00", {uart_send, tx_busy}); end
      total++;
      if ({tx_level, rx_empty, rx_overrun, tx_timeout, uart_dintx} !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL mid_reset_state: got %0d/%b/%b/%b/%h want 0/1/0/0/00", tx_level, rx_empty, rx_overrun, tx_timeout, uart_dintx);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      tick(3);
      total++;
      if ({tx_busy, tx_level, uart_send} !== 7'd0) begin bad++; $display("FAIL mid_no_restart: got %b want 0", {tx_busy, tx_level, uart_send}); end
   endtask

`ifdef UART_HOST_STATS_EN
   task automatic test_stats();
      int w;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'hE0 + i[7:0]; wr_en = 1'b1;
         tick(1);
         wr_en = 1'b0;
         w = 0;
         while (uart_send !== 1'b1 && w < 10) begin tick(1); w++; end
         w = 0;
         while (uart_send === 1'b1 && w < 200) begin tick(1); w++; end
         donetx_pulse();
         tick(4);
      end
      for (int i = 0; i < 17; i++) rx_byte(i[7:0], 1);
      total++;
      if ({tx_count, rx_count, drop_count} !== {16'd3, 16'd16, 8'd1}) begin bad++; $display("FAIL stats_counts: got %0d/%0d/%0d want 3/16/1", tx_count, rx_count, drop_count); end
      flag_clr = 1'b1;
      tick(1);
      flag_clr = 1'b0;
      total++;
      if ({tx_count, rx_count, drop_count, rx_overrun} !== {16'd3, 16'd16, 8'd1, 1'b0}) begin
         bad++;
         $display("FAIL stats_after_clr: got %0d/%0d/%0d/%b want 3/16/1/0", tx_count, rx_count, drop_count, rx_overrun);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_early_done();
      test_timeout();
      test_rx_overrun();
      test_rx_simul();
      test_reset_mid();
`ifdef UART_HOST_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
